// File: rtl/translation_pango_pipe_pkg.sv
// Shared widths, MSI state encoding and a width helper for the Pango PCIe translation layer.
`default_nettype none
package translation_pango_pipe_pkg;

   localparam int SIG_FC_CPLD_W    = 12;
   localparam int SIG_FC_CPLH_W    = 8;
   localparam int SIG_BARDECODE_W  = 8;
   localparam int SIG_CPLRID_W     = 16;
   localparam int SIG_LINKWIDTH_W  = 6;
   localparam int SIG_LINKRATE_W   = 4;
   localparam int SIG_SIZE_W       = 3;

   typedef enum logic [1:0] {
      MSI_IDLE = 2'd0,
      MSI_REQ  = 2'd1,
      MSI_WAIT = 2'd2
   } msi_state_t;

   // Ceiling log2 that never returns less than one bit.
   function automatic int clog2s(input int value);
      int res;
      res = 0;
      while ((1 << res) < value) res = res + 1;
      return (res < 1) ? 1 : res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/translation_pango_pipe_skid_buf.sv
// Two-entry skid buffer with a registered input-side ready.
`default_nettype none
module pango_skid_buf #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   logic [WIDTH-1:0] mem [2];
   logic             wr_ptr;
   logic             rd_ptr;
   logic [1:0]       count;
   logic [1:0]       count_nxt;
   logic             push;
   logic             pop;

   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign out_valid = (count != 2'd0);
   assign out_data  = mem[rd_ptr];

   always_comb begin
      count_nxt = count + 2'(push) - 2'(pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem[0]   <= '0;
         mem[1]   <= '0;
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         count    <= 2'd0;
         in_ready <= 1'b0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= in_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         count    <= count_nxt;
         // Ready looks at the post-edge occupancy so a full buffer never accepts.
         in_ready <= (count_nxt != 2'd2);
      end
   end

endmodule
`default_nettype wire

// File: rtl/translation_pango_pipe.sv
// Bridges the Pango AXI-stream PCIe core to the classic RX/TX TLP interface, MSI and config.
`default_nettype none
module translation_pango_pipe
   import translation_pango_pipe_pkg::*;
#(
   parameter int          C_PCI_DATA_WIDTH = 128,
   parameter logic [5:0]  C_LINK_WIDTH     = 6'b000100,
   parameter logic [3:0]  C_LINK_RATE      = 4'b0001
) (
   input  logic                                        CLK,
   input  logic                                        RST_N_IN,
   input  logic [C_PCI_DATA_WIDTH-1:0]                 M_AXIS_RX_TDATA,
   input  logic [C_PCI_DATA_WIDTH/32-1:0]              M_AXIS_RX_TKEEP,
   input  logic                                        M_AXIS_RX_TLAST,
   input  logic                                        M_AXIS_RX_TVALID,
   output logic                                        M_AXIS_RX_TREADY,
   output logic [C_PCI_DATA_WIDTH-1:0]                 S_AXIS_TX_TDATA,
   output logic                                        S_AXIS_TX_TLAST,
   output logic                                        S_AXIS_TX_TVALID,
   output logic                                        S_AXIS_TX_TUSER,
   input  logic                                        S_AXIS_TX_TREADY,
   input  logic [7:0]                                  CFG_BUS_NUMBER,
   input  logic [4:0]                                  CFG_DEVICE_NUMBER,
   input  logic [2:0]                                  CFG_MAX_PAYLOAD_SIZE,
   input  logic [2:0]                                  CFG_MAX_READ_REQUEST_SIZE,
   input  logic                                        CFG_BUS_MASTER_EN,
   input  logic                                        CFG_RCB,
   input  logic                                        CFG_INTERRUPT_MSIEN,
   input  logic [SIG_FC_CPLD_W-1:0]                    FC_CPLD,
   input  logic [SIG_FC_CPLH_W-1:0]                    FC_CPLH,
   output logic                                        CFG_INTERRUPT,
   input  logic                                        CFG_INTERRUPT_RDY,
   output logic [C_PCI_DATA_WIDTH-1:0]                 RX_TLP,
   output logic                                        RX_TLP_VALID,
   output logic                                        RX_TLP_START_FLAG,
   output logic [clog2s(C_PCI_DATA_WIDTH/32)-1:0]      RX_TLP_START_OFFSET,
   output logic                                        RX_TLP_END_FLAG,
   output logic [clog2s(C_PCI_DATA_WIDTH/32)-1:0]      RX_TLP_END_OFFSET,
   output logic [SIG_BARDECODE_W-1:0]                  RX_TLP_BAR_DECODE,
   input  logic                                        RX_TLP_READY,
   input  logic [C_PCI_DATA_WIDTH-1:0]                 TX_TLP,
   input  logic                                        TX_TLP_VALID,
   input  logic                                        TX_TLP_START_FLAG,
   input  logic [clog2s(C_PCI_DATA_WIDTH/32)-1:0]      TX_TLP_START_OFFSET,
   input  logic                                        TX_TLP_END_FLAG,
   input  logic [clog2s(C_PCI_DATA_WIDTH/32)-1:0]      TX_TLP_END_OFFSET,
   output logic                                        TX_TLP_READY,
   output logic [SIG_CPLRID_W-1:0]                     CONFIG_COMPLETER_ID,
   output logic                                        CONFIG_BUS_MASTER_ENABLE,
   output logic [SIG_LINKWIDTH_W-1:0]                  CONFIG_LINK_WIDTH,
   output logic [SIG_LINKRATE_W-1:0]                   CONFIG_LINK_RATE,
   output logic [SIG_SIZE_W-1:0]                       CONFIG_MAX_READ_REQUEST_SIZE,
   output logic [SIG_SIZE_W-1:0]                       CONFIG_MAX_PAYLOAD_SIZE,
   output logic                                        CONFIG_INTERRUPT_MSIENABLE,
   output logic                                        CONFIG_CPL_BOUNDARY_SEL,
   output logic [SIG_FC_CPLD_W-1:0]                    CONFIG_MAX_CPL_DATA,
   output logic [SIG_FC_CPLH_W-1:0]                    CONFIG_MAX_CPL_HDR,
   output logic                                        INTR_MSI_RDY,
   input  logic                                        INTR_MSI_REQUEST
);

   localparam int KW  = C_PCI_DATA_WIDTH / 32;
   localparam int OW  = clog2s(KW);
   localparam int RXW = C_PCI_DATA_WIDTH + 2 + OW;
   localparam int TXW = C_PCI_DATA_WIDTH + 1;

   logic           in_pkt;
   logic [OW-1:0]  rx_end_off;
   logic [RXW-1:0] rx_out;
   logic           unused_tx;
   msi_state_t     msi_state;

   // Highest kept dword on a last beat; an empty keep reports offset zero.
   always_comb begin
      rx_end_off = '0;
      if (M_AXIS_RX_TLAST) begin
         for (int i = 0; i < KW; i++) begin
            if (M_AXIS_RX_TKEEP[i]) rx_end_off = i[OW-1:0];
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N_IN) begin
      if (!RST_N_IN) begin
         in_pkt <= 1'b0;
      end else if (M_AXIS_RX_TVALID && M_AXIS_RX_TREADY) begin
         in_pkt <= !M_AXIS_RX_TLAST;
      end
   end

   pango_skid_buf #(.WIDTH(RXW)) u_rx_skid (
      .clk       (CLK),
      .rst_n     (RST_N_IN),
      .in_valid  (M_AXIS_RX_TVALID),
      .in_ready  (M_AXIS_RX_TREADY),
      .in_data   ({M_AXIS_RX_TDATA, !in_pkt, M_AXIS_RX_TLAST, rx_end_off}),
      .out_valid (RX_TLP_VALID),
      .out_ready (RX_TLP_READY),
      .out_data  (rx_out)
   );

   assign {RX_TLP, RX_TLP_START_FLAG, RX_TLP_END_FLAG, RX_TLP_END_OFFSET} = rx_out;
   assign RX_TLP_START_OFFSET = '0;
   assign RX_TLP_BAR_DECODE   = '0;

   pango_skid_buf #(.WIDTH(TXW)) u_tx_skid (
      .clk       (CLK),
      .rst_n     (RST_N_IN),
      .in_valid  (TX_TLP_VALID),
      .in_ready  (TX_TLP_READY),
      .in_data   ({TX_TLP, TX_TLP_END_FLAG}),
      .out_valid (S_AXIS_TX_TVALID),
      .out_ready (S_AXIS_TX_TREADY),
      .out_data  ({S_AXIS_TX_TDATA, S_AXIS_TX_TLAST})
   );

   assign S_AXIS_TX_TUSER = 1'b0;
   assign unused_tx       = ^{TX_TLP_START_FLAG, TX_TLP_START_OFFSET, TX_TLP_END_OFFSET};

   always_ff @(posedge CLK or negedge RST_N_IN) begin
      if (!RST_N_IN) begin
         CONFIG_COMPLETER_ID          <= '0;
         CONFIG_BUS_MASTER_ENABLE     <= 1'b0;
         CONFIG_LINK_WIDTH            <= '0;
         CONFIG_LINK_RATE             <= '0;
         CONFIG_MAX_READ_REQUEST_SIZE <= '0;
         CONFIG_MAX_PAYLOAD_SIZE      <= '0;
         CONFIG_INTERRUPT_MSIENABLE   <= 1'b0;
         CONFIG_CPL_BOUNDARY_SEL      <= 1'b0;
         CONFIG_MAX_CPL_DATA          <= '0;
         CONFIG_MAX_CPL_HDR           <= '0;
      end else begin
         CONFIG_COMPLETER_ID          <= {CFG_BUS_NUMBER, CFG_DEVICE_NUMBER, 3'b000};
         CONFIG_BUS_MASTER_ENABLE     <= CFG_BUS_MASTER_EN;
         CONFIG_LINK_WIDTH            <= C_LINK_WIDTH;
         CONFIG_LINK_RATE             <= C_LINK_RATE;
         CONFIG_MAX_READ_REQUEST_SIZE <= CFG_MAX_READ_REQUEST_SIZE;
         CONFIG_MAX_PAYLOAD_SIZE      <= CFG_MAX_PAYLOAD_SIZE;
         CONFIG_INTERRUPT_MSIENABLE   <= CFG_INTERRUPT_MSIEN;
         CONFIG_CPL_BOUNDARY_SEL      <= CFG_RCB;
         CONFIG_MAX_CPL_DATA          <= FC_CPLD;
         CONFIG_MAX_CPL_HDR           <= FC_CPLH;
      end
   end

   // Outputs are registered alongside the state so they reflect the state being entered.
   always_ff @(posedge CLK or negedge RST_N_IN) begin
      if (!RST_N_IN) begin
         msi_state     <= MSI_IDLE;
         CFG_INTERRUPT <= 1'b0;
         INTR_MSI_RDY  <= 1'b0;
      end else begin
         case (msi_state)
            MSI_IDLE: begin
               if (INTR_MSI_REQUEST && CFG_INTERRUPT_MSIEN) begin
                  msi_state     <= MSI_REQ;
                  CFG_INTERRUPT <= 1'b1;
                  INTR_MSI_RDY  <= 1'b0;
               end else begin
                  CFG_INTERRUPT <= 1'b0;
                  INTR_MSI_RDY  <= CFG_INTERRUPT_MSIEN;
               end
            end
            MSI_REQ: begin
               if (!CFG_INTERRUPT_MSIEN) begin
                  msi_state     <= MSI_IDLE;
                  CFG_INTERRUPT <= 1'b0;
                  INTR_MSI_RDY  <= 1'b0;
               end else if (CFG_INTERRUPT_RDY) begin
                  msi_state     <= MSI_WAIT;
                  CFG_INTERRUPT <= 1'b0;
                  INTR_MSI_RDY  <= 1'b0;
               end else begin
                  CFG_INTERRUPT <= 1'b1;
                  INTR_MSI_RDY  <= 1'b0;
               end
            end
            MSI_WAIT: begin
               CFG_INTERRUPT <= 1'b0;
               if (!CFG_INTERRUPT_RDY) begin
                  msi_state    <= MSI_IDLE;
                  INTR_MSI_RDY <= CFG_INTERRUPT_MSIEN;
               end else begin
                  INTR_MSI_RDY <= 1'b0;
               end
            end
            default: begin
               msi_state     <= MSI_IDLE;
               CFG_INTERRUPT <= 1'b0;
               INTR_MSI_RDY  <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_translation_pango_pipe.sv
// Self-checking bench: transaction-level scoreboard for both skid paths, MSI and config models.
`default_nettype none
module tb_translation_pango_pipe;
   import translation_pango_pipe_pkg::*;

   localparam int W  = 128;
   localparam int KW = 4;
   localparam int OW = 2;

   logic           CLK = 1'b0;
   logic           RST_N_IN;
   logic [W-1:0]   M_AXIS_RX_TDATA;
   logic [KW-1:0]  M_AXIS_RX_TKEEP;
   logic           M_AXIS_RX_TLAST, M_AXIS_RX_TVALID, M_AXIS_RX_TREADY;
   logic [W-1:0]   S_AXIS_TX_TDATA;
   logic           S_AXIS_TX_TLAST, S_AXIS_TX_TVALID, S_AXIS_TX_TUSER, S_AXIS_TX_TREADY;
   logic [7:0]     CFG_BUS_NUMBER;
   logic [4:0]     CFG_DEVICE_NUMBER;
   logic [2:0]     CFG_MAX_PAYLOAD_SIZE, CFG_MAX_READ_REQUEST_SIZE;
   logic           CFG_BUS_MASTER_EN, CFG_RCB, CFG_INTERRUPT_MSIEN;
   logic [11:0]    FC_CPLD;
   logic [7:0]     FC_CPLH;
   logic           CFG_INTERRUPT, CFG_INTERRUPT_RDY;
   logic [W-1:0]   RX_TLP;
   logic           RX_TLP_VALID, RX_TLP_START_FLAG, RX_TLP_END_FLAG, RX_TLP_READY;
   logic [OW-1:0]  RX_TLP_START_OFFSET, RX_TLP_END_OFFSET;
   logic [7:0]     RX_TLP_BAR_DECODE;
   logic [W-1:0]   TX_TLP;
   logic           TX_TLP_VALID, TX_TLP_START_FLAG, TX_TLP_END_FLAG, TX_TLP_READY;
   logic [OW-1:0]  TX_TLP_START_OFFSET, TX_TLP_END_OFFSET;
   logic [15:0]    CONFIG_COMPLETER_ID;
   logic           CONFIG_BUS_MASTER_ENABLE;
   logic [5:0]     CONFIG_LINK_WIDTH;
   logic [3:0]     CONFIG_LINK_RATE;
   logic [2:0]     CONFIG_MAX_READ_REQUEST_SIZE, CONFIG_MAX_PAYLOAD_SIZE;
   logic           CONFIG_INTERRUPT_MSIENABLE, CONFIG_CPL_BOUNDARY_SEL;
   logic [11:0]    CONFIG_MAX_CPL_DATA;
   logic [7:0]     CONFIG_MAX_CPL_HDR;
   logic           INTR_MSI_RDY, INTR_MSI_REQUEST;

   translation_pango_pipe #(.C_PCI_DATA_WIDTH(W)) dut (
      .CLK(CLK), .RST_N_IN(RST_N_IN),
      .M_AXIS_RX_TDATA(M_AXIS_RX_TDATA), .M_AXIS_RX_TKEEP(M_AXIS_RX_TKEEP),
      .M_AXIS_RX_TLAST(M_AXIS_RX_TLAST), .M_AXIS_RX_TVALID(M_AXIS_RX_TVALID),
      .M_AXIS_RX_TREADY(M_AXIS_RX_TREADY),
      .S_AXIS_TX_TDATA(S_AXIS_TX_TDATA), .S_AXIS_TX_TLAST(S_AXIS_TX_TLAST),
      .S_AXIS_TX_TVALID(S_AXIS_TX_TVALID), .S_AXIS_TX_TUSER(S_AXIS_TX_TUSER),
      .S_AXIS_TX_TREADY(S_AXIS_TX_TREADY),
      .CFG_BUS_NUMBER(CFG_BUS_NUMBER), .CFG_DEVICE_NUMBER(CFG_DEVICE_NUMBER),
      .CFG_MAX_PAYLOAD_SIZE(CFG_MAX_PAYLOAD_SIZE),
      .CFG_MAX_READ_REQUEST_SIZE(CFG_MAX_READ_REQUEST_SIZE),
      .CFG_BUS_MASTER_EN(CFG_BUS_MASTER_EN), .CFG_RCB(CFG_RCB),
      .CFG_INTERRUPT_MSIEN(CFG_INTERRUPT_MSIEN),
      .FC_CPLD(FC_CPLD), .FC_CPLH(FC_CPLH),
      .CFG_INTERRUPT(CFG_INTERRUPT), .CFG_INTERRUPT_RDY(CFG_INTERRUPT_RDY),
      .RX_TLP(RX_TLP), .RX_TLP_VALID(RX_TLP_VALID), .RX_TLP_START_FLAG(RX_TLP_START_FLAG),
      .RX_TLP_START_OFFSET(RX_TLP_START_OFFSET), .RX_TLP_END_FLAG(RX_TLP_END_FLAG),
      .RX_TLP_END_OFFSET(RX_TLP_END_OFFSET), .RX_TLP_BAR_DECODE(RX_TLP_BAR_DECODE),
      .RX_TLP_READY(RX_TLP_READY),
      .TX_TLP(TX_TLP), .TX_TLP_VALID(TX_TLP_VALID), .TX_TLP_START_FLAG(TX_TLP_START_FLAG),
      .TX_TLP_START_OFFSET(TX_TLP_START_OFFSET), .TX_TLP_END_FLAG(TX_TLP_END_FLAG),
      .TX_TLP_END_OFFSET(TX_TLP_END_OFFSET), .TX_TLP_READY(TX_TLP_READY),
      .CONFIG_COMPLETER_ID(CONFIG_COMPLETER_ID),
      .CONFIG_BUS_MASTER_ENABLE(CONFIG_BUS_MASTER_ENABLE),
      .CONFIG_LINK_WIDTH(CONFIG_LINK_WIDTH), .CONFIG_LINK_RATE(CONFIG_LINK_RATE),
      .CONFIG_MAX_READ_REQUEST_SIZE(CONFIG_MAX_READ_REQUEST_SIZE),
      .CONFIG_MAX_PAYLOAD_SIZE(CONFIG_MAX_PAYLOAD_SIZE),
      .CONFIG_INTERRUPT_MSIENABLE(CONFIG_INTERRUPT_MSIENABLE),
      .CONFIG_CPL_BOUNDARY_SEL(CONFIG_CPL_BOUNDARY_SEL),
      .CONFIG_MAX_CPL_DATA(CONFIG_MAX_CPL_DATA), .CONFIG_MAX_CPL_HDR(CONFIG_MAX_CPL_HDR),
      .INTR_MSI_RDY(INTR_MSI_RDY), .INTR_MSI_REQUEST(INTR_MSI_REQUEST)
   );

   always #5 CLK = ~CLK;

   typedef struct { logic [W-1:0] d; logic s; logic e; logic [OW-1:0] o; } rx_beat_t;
   typedef struct { logic [W-1:0] d; logic e; } tx_beat_t;

   rx_beat_t rxq[$], rx_log[$];
   tx_beat_t txq[$], tx_log[$];
   int       total = 0;
   int       bad   = 0;
   int       int_cycles = 0;
   bit       m_in_pkt = 0;
   bit       post = 0;
   int       msi_st = 0;   // 0 idle, 1 requesting, 2 waiting for grant release
   bit       msien_snap = 0;
   logic [15:0] s_cid;
   logic [2:0]  s_mrrs, s_mps;
   logic        s_bme, s_msien, s_rcb;
   logic [11:0] s_cpld;
   logic [7:0]  s_cplh;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [OW-1:0] top_keep(input logic [KW-1:0] k);
      logic [OW-1:0] r;
      r = '0;
      for (int i = 0; i < KW; i++) if (k[i]) r = OW'(i);
      return r;
   endfunction

   always @(negedge CLK) begin
      bit rx_rdy_m, tx_rdy_m;
      rx_beat_t rb;
      tx_beat_t tb;
      if (!RST_N_IN) begin
         chk("rst_rx", {M_AXIS_RX_TREADY, RX_TLP, RX_TLP_VALID, RX_TLP_START_FLAG, RX_TLP_END_FLAG,
                        RX_TLP_START_OFFSET, RX_TLP_END_OFFSET, RX_TLP_BAR_DECODE}, '0);
         chk("rst_tx", {TX_TLP_READY, S_AXIS_TX_TDATA, S_AXIS_TX_TLAST, S_AXIS_TX_TVALID, S_AXIS_TX_TUSER}, '0);
         chk("rst_cfg", {CONFIG_COMPLETER_ID, CONFIG_BUS_MASTER_ENABLE, CONFIG_LINK_WIDTH, CONFIG_LINK_RATE,
                         CONFIG_MAX_READ_REQUEST_SIZE, CONFIG_MAX_PAYLOAD_SIZE, CONFIG_INTERRUPT_MSIENABLE,
                         CONFIG_CPL_BOUNDARY_SEL, CONFIG_MAX_CPL_DATA, CONFIG_MAX_CPL_HDR,
                         CFG_INTERRUPT, INTR_MSI_RDY}, '0);
         rxq.delete(); txq.delete();
         m_in_pkt = 0; post = 0; msi_st = 0;
      end else begin
         if (!post) begin
            chk("first_cycle_ready", {M_AXIS_RX_TREADY, TX_TLP_READY, RX_TLP_VALID, S_AXIS_TX_TVALID}, '0);
            chk("first_cycle_ctl", {CFG_INTERRUPT, INTR_MSI_RDY, CONFIG_COMPLETER_ID}, '0);
         end else begin
            chk("rx_ready", M_AXIS_RX_TREADY, rxq.size() < 2);
            chk("rx_valid", RX_TLP_VALID, rxq.size() > 0);
            if (rxq.size() > 0)
               chk("rx_beat", {RX_TLP, RX_TLP_START_FLAG, RX_TLP_END_FLAG, RX_TLP_END_OFFSET},
                   {rxq[0].d, rxq[0].s, rxq[0].e, rxq[0].o});
            chk("rx_zero_fields", {RX_TLP_START_OFFSET, RX_TLP_BAR_DECODE}, '0);
            chk("tx_ready", TX_TLP_READY, txq.size() < 2);
            chk("tx_valid", S_AXIS_TX_TVALID, txq.size() > 0);
            if (txq.size() > 0)
               chk("tx_beat", {S_AXIS_TX_TDATA, S_AXIS_TX_TLAST}, {txq[0].d, txq[0].e});
            chk("tx_user", S_AXIS_TX_TUSER, 1'b0);
            chk("cfg_regs", {CONFIG_COMPLETER_ID, CONFIG_BUS_MASTER_ENABLE, CONFIG_LINK_WIDTH, CONFIG_LINK_RATE,
                             CONFIG_MAX_READ_REQUEST_SIZE, CONFIG_MAX_PAYLOAD_SIZE, CONFIG_INTERRUPT_MSIENABLE,
                             CONFIG_CPL_BOUNDARY_SEL, CONFIG_MAX_CPL_DATA, CONFIG_MAX_CPL_HDR},
                {s_cid, s_bme, 6'b000100, 4'b0001, s_mrrs, s_mps, s_msien, s_rcb, s_cpld, s_cplh});
            chk("msi_int", CFG_INTERRUPT, msi_st == 1);
            chk("msi_rdy", INTR_MSI_RDY, (msi_st == 0) && msien_snap);
            if (CFG_INTERRUPT) int_cycles++;
         end
         // Predict what the coming edge transfers, from the model's own occupancy.
         rx_rdy_m = post && (rxq.size() < 2);
         tx_rdy_m = post && (txq.size() < 2);
         if (rxq.size() > 0 && RX_TLP_READY) rx_log.push_back(rxq.pop_front());
         if (M_AXIS_RX_TVALID && rx_rdy_m) begin
            rb.d = M_AXIS_RX_TDATA; rb.s = !m_in_pkt; rb.e = M_AXIS_RX_TLAST;
            rb.o = M_AXIS_RX_TLAST ? top_keep(M_AXIS_RX_TKEEP) : '0;
            rxq.push_back(rb);
            m_in_pkt = !M_AXIS_RX_TLAST;
         end
         if (txq.size() > 0 && S_AXIS_TX_TREADY) tx_log.push_back(txq.pop_front());
         if (TX_TLP_VALID && tx_rdy_m) begin
            tb.d = TX_TLP; tb.e = TX_TLP_END_FLAG;
            txq.push_back(tb);
         end
         s_cid = {CFG_BUS_NUMBER, CFG_DEVICE_NUMBER, 3'b000};
         s_bme = CFG_BUS_MASTER_EN; s_mrrs = CFG_MAX_READ_REQUEST_SIZE; s_mps = CFG_MAX_PAYLOAD_SIZE;
         s_msien = CFG_INTERRUPT_MSIEN; s_rcb = CFG_RCB; s_cpld = FC_CPLD; s_cplh = FC_CPLH;
         msien_snap = CFG_INTERRUPT_MSIEN;
         case (msi_st)
            0: if (INTR_MSI_REQUEST && CFG_INTERRUPT_MSIEN) msi_st = 1;
            1: if (!CFG_INTERRUPT_MSIEN) msi_st = 0; else if (CFG_INTERRUPT_RDY) msi_st = 2;
            default: if (!CFG_INTERRUPT_RDY) msi_st = 0;
         endcase
         post = 1;
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic send_rx(input logic [W-1:0] d, input logic [KW-1:0] k, input logic l);
      int n;
      M_AXIS_RX_TDATA = d; M_AXIS_RX_TKEEP = k; M_AXIS_RX_TLAST = l; M_AXIS_RX_TVALID = 1'b1;
      n = 0;
      @(negedge CLK);
      while (!M_AXIS_RX_TREADY && n < 50) begin @(negedge CLK); n++; end
      if (n >= 50) begin total++; bad++; $display("FAIL rx_send_timeout waited=%0d limit=50", n); end
      step(1);
   endtask

   task automatic send_tx(input logic [W-1:0] d, input logic e);
      int n;
      TX_TLP = d; TX_TLP_END_FLAG = e; TX_TLP_START_FLAG = 1'b0; TX_TLP_VALID = 1'b1;
      n = 0;
      @(negedge CLK);
      while (!TX_TLP_READY && n < 50) begin @(negedge CLK); n++; end
      if (n >= 50) begin total++; bad++; $display("FAIL tx_send_timeout waited=%0d limit=50", n); end
      step(1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((rxq.size() != 0 || txq.size() != 0) && n < 60) begin step(1); n++; end
      chk("drain", 32'(rxq.size() + txq.size()), 32'd0);
      step(1);
   endtask

   initial begin
      int b;
      RST_N_IN = 0;
      M_AXIS_RX_TDATA = '0; M_AXIS_RX_TKEEP = '0; M_AXIS_RX_TLAST = 0; M_AXIS_RX_TVALID = 0;
      S_AXIS_TX_TREADY = 1; RX_TLP_READY = 1;
      TX_TLP = '0; TX_TLP_VALID = 0; TX_TLP_START_FLAG = 0; TX_TLP_END_FLAG = 0;
      TX_TLP_START_OFFSET = '0; TX_TLP_END_OFFSET = '0;
      CFG_BUS_NUMBER = 8'h5a; CFG_DEVICE_NUMBER = 5'h1f; CFG_MAX_PAYLOAD_SIZE = 3'd1;
      CFG_MAX_READ_REQUEST_SIZE = 3'd2; CFG_BUS_MASTER_EN = 1; CFG_RCB = 1; CFG_INTERRUPT_MSIEN = 0;
      FC_CPLD = 12'habc; FC_CPLH = 8'h40; CFG_INTERRUPT_RDY = 0; INTR_MSI_REQUEST = 0;
      step(3);
      RST_N_IN = 1;
      step(1);
      chk("ready_rise", {M_AXIS_RX_TREADY, TX_TLP_READY}, 2'b11);

      // Three-beat TLP ending with two kept dwords.
      b = rx_log.size();
      send_rx(128'h1111, 4'b1111, 0);
      send_rx(128'h2222, 4'b1111, 0);
      send_rx(128'h3333, 4'b0011, 1);
      M_AXIS_RX_TVALID = 0;
      drain();
      chk("tlp3_b1", {rx_log[b].s, rx_log[b].e}, 2'b10);
      chk("tlp3_b2", {rx_log[b+1].s, rx_log[b+1].e}, 2'b00);
      chk("tlp3_b3", {rx_log[b+2].s, rx_log[b+2].e, rx_log[b+2].o}, 4'b0101);

      // Single-beat TLPs, full keep and empty keep.
      b = rx_log.size();
      send_rx(128'h4444, 4'b1111, 1);
      send_rx(128'h5555, 4'b0000, 1);
      M_AXIS_RX_TVALID = 0;
      drain();
      chk("single_full", {rx_log[b].s, rx_log[b].e, rx_log[b].o}, 4'b1111);
      chk("single_empty", {rx_log[b+1].s, rx_log[b+1].e, rx_log[b+1].o}, 4'b1100);

      // Eight back-to-back beats against an alternating consumer.
      b = rx_log.size();
      fork
         begin
            for (int i = 0; i < 8; i++) send_rx(128'h100 + 128'(i), 4'b1111, i == 7);
            M_AXIS_RX_TVALID = 0;
         end
         begin
            repeat (30) begin RX_TLP_READY = ~RX_TLP_READY; step(1); end
         end
      join
      RX_TLP_READY = 1;
      drain();
      chk("toggle_count", 32'(rx_log.size() - b), 32'd8);
      for (int i = 0; i < 8; i++) chk("toggle_order", rx_log[b+i].d, 128'h100 + 128'(i));

      // TX path under a stalling core.
      b = tx_log.size();
      fork
         begin
            for (int i = 0; i < 5; i++) send_tx(128'hA00 + 128'(i), i == 4);
            TX_TLP_VALID = 0;
         end
         begin
            repeat (20) begin S_AXIS_TX_TREADY = ~S_AXIS_TX_TREADY; step(1); end
         end
      join
      S_AXIS_TX_TREADY = 1;
      drain();
      chk("tx_count", 32'(tx_log.size() - b), 32'd5);
      chk("tx_last", {tx_log[b+4].d, tx_log[b+4].e, tx_log[b+3].e}, {128'hA04, 2'b10});

      // MSI handshake with a grant four cycles after the request.
      CFG_INTERRUPT_MSIEN = 1;
      step(2);
      int_cycles = 0;
      INTR_MSI_REQUEST = 1;
      step(1);
      INTR_MSI_REQUEST = 0;
      step(3);
      CFG_INTERRUPT_RDY = 1;
      step(3);
      INTR_MSI_REQUEST = 1;
      step(1);
      INTR_MSI_REQUEST = 0;
      chk("msi_wait_rdy", {CFG_INTERRUPT, INTR_MSI_RDY}, 2'b00);
      CFG_INTERRUPT_RDY = 0;
      step(2);
      chk("msi_int_cycles", 32'(int_cycles), 32'd4);
      chk("msi_idle_rdy", {CFG_INTERRUPT, INTR_MSI_RDY}, 2'b01);
      INTR_MSI_REQUEST = 1;
      step(1);
      INTR_MSI_REQUEST = 0;
      chk("msi_req2", CFG_INTERRUPT, 1'b1);
      CFG_INTERRUPT_MSIEN = 0;
      step(1);
      chk("msi_abort", {CFG_INTERRUPT, INTR_MSI_RDY}, 2'b00);

      // Config registering.
      CFG_BUS_NUMBER = 8'h12; CFG_DEVICE_NUMBER = 5'h3;
      step(1);
      chk("completer_id", CONFIG_COMPLETER_ID, 16'h1218);
      chk("link_width", CONFIG_LINK_WIDTH, 6'b000100);

      // Reset in the middle of a buffered packet.
      RX_TLP_READY = 0;
      send_rx(128'h7001, 4'b1111, 0);
      send_rx(128'h7002, 4'b1111, 0);
      M_AXIS_RX_TVALID = 0;
      step(1);
      RST_N_IN = 0;
      #1;
      chk("async_rst", {RX_TLP_VALID, RX_TLP, M_AXIS_RX_TREADY, TX_TLP_READY, CONFIG_COMPLETER_ID}, '0);
      step(2);
      RST_N_IN = 1;
      step(1);
      chk("ready_after_rst", {M_AXIS_RX_TREADY, TX_TLP_READY}, 2'b11);
      RX_TLP_READY = 1;
      b = rx_log.size();
      send_rx(128'h8001, 4'b0111, 1);
      M_AXIS_RX_TVALID = 0;
      drain();
      chk("post_rst_start", {rx_log[b].d, rx_log[b].s, rx_log[b].e, rx_log[b].o}, {128'h8001, 4'b1110});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout time=%0t limit=200000", $time);
      $fatal(1);
   end

endmodule
`default_nettype wire
